// File: rtl/ram_access_ctrl.sv
// Queued command front-end for a single-port asynchronous-bus RAM.
// Requests are buffered in a FIFO and replayed through a small bus-sequencing FSM.
module ram_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  idle,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        TURN    = 3'd4
    } state_t;

    state_t state, next_state;

    logic                  fifo_we    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full, empty, push, pop;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign idle      = empty && (state == IDLE);

    // Queue storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= req_we;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (pop) begin
            cmd_addr  <= fifo_addr[rd_ptr];
            cmd_wdata <= fifo_wdata[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = fifo_we[rd_ptr] ? WRITE : RD_ADDR;
                end
            end
            WRITE:   next_state = IDLE;
            RD_ADDR: next_state = RD_DATA;
            RD_DATA: next_state = TURN;
            TURN:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes depend on the state register alone so they drop the moment reset asserts.
    always_comb begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
        ram_oe = 1'b0;
        case (state)
            WRITE: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
            end
            RD_ADDR: begin
                ram_cs = 1'b1;
            end
            RD_DATA: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
            end
            default: begin
                ram_cs = 1'b0;
            end
        endcase
    end

    // The command register only changes on a pop, so the address holds through IDLE.
    assign ram_addr = cmd_addr;
    assign ram_data = (state == WRITE) ? cmd_wdata : 'z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == RD_DATA);
            if (state == RD_DATA) begin
                rsp_rdata <= ram_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural single-port RAM on the shared bus.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        idle;
    logic [3:0]  ram_addr;
    wire  [31:0] ram_data;
    logic        ram_cs, ram_we, ram_oe;

    int total = 0;
    int bad = 0;

    ram_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .idle(idle),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    always #5 clk = ~clk;

    // RAM: address latched in the cs-without-oe cycle, data driven while oe is high.
    logic [31:0] mem [16];
    logic [31:0] rd_q = '0;
    logic [3:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_n = 0;

    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_data;
            if (wr_n < 64) begin
                wr_addr[wr_n] <= ram_addr;
                wr_data[wr_n] <= ram_data;
                wr_n          <= wr_n + 1;
            end
        end
        if (ram_cs && !ram_we && !ram_oe) rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe) ? rd_q : 'z;

    logic [31:0] rsp_mem [64];
    int          rsp_n = 0;
    int          over_cnt = 0;

    always @(negedge clk) begin
        if (rsp_valid && rsp_n < 64) begin
            rsp_mem[rsp_n] = rsp_rdata;
            rsp_n++;
        end
        if (dut.count > 3'd4) over_cnt++;
    end

    task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL send_ready: req_ready=%0b required=1", req_ready);
        end
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL wait_idle: idle=%0b required=1", idle);
        end
    endtask

    task automatic test_reset();
        #2;
        total += 8;
        if (ram_cs !== 1'b0)     begin bad++; $display("FAIL reset_cs: got %0b want 0", ram_cs); end
        if (ram_we !== 1'b0)     begin bad++; $display("FAIL reset_we: got %0b want 0", ram_we); end
        if (ram_oe !== 1'b0)     begin bad++; $display("FAIL reset_oe: got %0b want 0", ram_oe); end
        if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        if (rsp_rdata !== '0)    begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        if (ram_addr !== '0)     begin bad++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        if (req_ready !== 1'b1)  begin bad++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
        if (idle !== 1'b1)       begin bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int r0;
        send(1'b1, 4'd3, 32'hDEADBEEF);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== 4'd3 || ram_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_bus: cs/we/oe=%b addr=%h data=%h want 110 3 deadbeef",
                     {ram_cs, ram_we, ram_oe}, ram_addr, ram_data);
        end
        @(negedge clk);
        total++;
        if (mem[3] !== 32'hDEADBEEF) begin bad++; $display("FAIL write_mem: got %h want deadbeef", mem[3]); end
        r0 = rsp_n;
        send(1'b0, 4'd3, 32'h0);
        @(negedge clk); req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_lat_e0: rsp_valid=%0b want 0", rsp_valid); end
        @(negedge clk);
        total++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b100 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rd_addr_phase: cs/we/oe=%b rsp_valid=%0b want 100 0", {ram_cs, ram_we, ram_oe}, rsp_valid);
        end
        @(negedge clk);
        total++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b101 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rd_data_phase: cs/we/oe=%b rsp_valid=%0b want 101 0", {ram_cs, ram_we, ram_oe}, rsp_valid);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || ram_cs !== 1'b0) begin
            bad++; $display("FAIL rd_rsp: rsp_valid=%0b rdata=%h cs=%0b want 1 deadbeef 0", rsp_valid, rsp_rdata, ram_cs);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_rsp_pulse: rsp_valid=%0b rdata=%h want 0 deadbeef", rsp_valid, rsp_rdata);
        end
        wait_idle();
        total++;
        if (rsp_n - r0 != 1) begin bad++; $display("FAIL rd_rsp_count: got %0d want 1", rsp_n - r0); end
    endtask

    task automatic test_queue_full();
        int r0;
        int n = 0;
        for (int i = 0; i < 6; i++) send(1'b1, 4'(8 + i), 32'hC0DE0000 + 32'(8 + i));
        wait_idle();
        r0 = rsp_n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd8;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d: got %0b want 1", k, req_ready); end
            req_addr = 4'(8 + k);
            @(posedge clk);
        end
        @(negedge clk);
        total += 2;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %0b want 0", req_ready); end
        if (dut.count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", dut.count); end
        req_addr = 4'd13;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL full_stall_cycles: got %0d want 1", n); end
        @(posedge clk);
        wait_idle();
        total++;
        if (rsp_n - r0 != 6) begin bad++; $display("FAIL full_rsp_count: got %0d want 6", rsp_n - r0); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rsp_mem[r0 + i] !== 32'hC0DE0000 + 32'(8 + i)) begin
                bad++; $display("FAIL full_order_%0d: got %h want %h", i, rsp_mem[r0 + i], 32'hC0DE0000 + 32'(8 + i));
            end
        end
    endtask

    task automatic test_pointer_wrap();
        int r0 = rsp_n;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 4'(i), 32'hA5A50000 + 32'(i));
            send(1'b0, 4'(i), 32'h0);
        end
        wait_idle();
        total += 2;
        if (rsp_n - r0 != 10) begin bad++; $display("FAIL wrap_rsp_count: got %0d want 10", rsp_n - r0); end
        if (over_cnt != 0) begin bad++; $display("FAIL wrap_count_max: overflow cycles %0d want 0", over_cnt); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (rsp_mem[r0 + i] !== 32'hA5A50000 + 32'(i)) begin
                bad++; $display("FAIL wrap_data_%0d: got %h want %h", i, rsp_mem[r0 + i], 32'hA5A50000 + 32'(i));
            end
        end
    endtask

    task automatic test_turnaround();
        int r0;
        int idx_oe = -1;
        int idx_we = -1;
        int clash = 0;
        logic cs_h [12];
        send(1'b0, 4'd1, 32'h0);
        send(1'b1, 4'd2, 32'h12345678);
        @(negedge clk); req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (ram_oe && ram_we) clash++;
            if (ram_oe) idx_oe = c;
            if (ram_we && idx_we < 0) idx_we = c;
            cs_h[c] = ram_cs;
            @(negedge clk);
        end
        total += 3;
        if (clash != 0) begin bad++; $display("FAIL turn_clash: got %0d cycles want 0", clash); end
        if (idx_oe < 0 || idx_we != idx_oe + 3) begin
            bad++; $display("FAIL turn_order: oe_cycle=%0d we_cycle=%0d want we=oe+3", idx_oe, idx_we);
        end
        if (idx_oe < 0 || idx_oe > 10 || cs_h[idx_oe + 1] !== 1'b0) begin
            bad++; $display("FAIL turn_cs: cs after read not low (oe_cycle=%0d)", idx_oe);
        end
        wait_idle();
        r0 = rsp_n;
        send(1'b0, 4'd2, 32'h0);
        wait_idle();
        total++;
        if (rsp_n - r0 != 1 || rsp_mem[r0] !== 32'h12345678) begin
            bad++; $display("FAIL turn_readback: n=%0d data=%h want 1 12345678", rsp_n - r0, rsp_mem[r0]);
        end
    endtask

    task automatic test_push_pop();
        int w0 = wr_n;
        int r0;
        send(1'b1, 4'd5, 32'd1);
        send(1'b1, 4'd5, 32'd2);
        send(1'b1, 4'd5, 32'd3);
        @(negedge clk);
        total++;
        if (dut.count !== 3'd2) begin bad++; $display("FAIL pp_count_before: got %0d want 2", dut.count); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 32'd4;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        total++;
        if (dut.count !== 3'd2) begin bad++; $display("FAIL pp_count_after: got %0d want 2", dut.count); end
        wait_idle();
        total++;
        if (wr_n - w0 != 4) begin bad++; $display("FAIL pp_write_count: got %0d want 4", wr_n - w0); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_data[w0 + i] !== 32'(i + 1) || wr_addr[w0 + i] !== 4'd5) begin
                bad++; $display("FAIL pp_order_%0d: addr=%h data=%h want 5 %h", i, wr_addr[w0 + i], wr_data[w0 + i], 32'(i + 1));
            end
        end
        r0 = rsp_n;
        send(1'b0, 4'd5, 32'h0);
        wait_idle();
        total++;
        if (rsp_mem[r0] !== 32'd4) begin bad++; $display("FAIL pp_readback: got %h want 4", rsp_mem[r0]); end
    endtask

    task automatic test_mid_reset();
        int r0;
        int w0;
        int n = 0;
        send(1'b0, 4'd7, 32'h0);
        send(1'b1, 4'd8, 32'hBAD00008);
        send(1'b1, 4'd9, 32'hBAD00009);
        @(negedge clk); req_valid = 1'b0;
        while (!ram_oe && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!ram_oe) begin bad++; $display("FAIL mr_reach_rd_data: ram_oe=%0b want 1", ram_oe); end
        r0 = rsp_n;
        w0 = wr_n;
        #2 rst_n = 1'b0;
        #1;
        total += 5;
        if (ram_cs !== 1'b0)    begin bad++; $display("FAIL mr_cs: got %0b want 0", ram_cs); end
        if (ram_oe !== 1'b0)    begin bad++; $display("FAIL mr_oe: got %0b want 0", ram_oe); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_rsp_valid: got %0b want 0", rsp_valid); end
        if (idle !== 1'b1)      begin bad++; $display("FAIL mr_idle: got %0b want 1", idle); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL mr_ready: got %0b want 1", req_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4; req_wdata = 32'h44444444;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        total++;
        if (dut.count !== 3'd1) begin bad++; $display("FAIL mr_first_accept: count=%0d want 1", dut.count); end
        wait_idle();
        total += 2;
        if (rsp_n != r0) begin bad++; $display("FAIL mr_no_rsp: got %0d responses want 0", rsp_n - r0); end
        if (wr_n - w0 != 1 || wr_addr[w0] !== 4'd4 || wr_data[w0] !== 32'h44444444) begin
            bad++; $display("FAIL mr_discard: writes=%0d addr=%h data=%h want 1 4 44444444", wr_n - w0, wr_addr[w0], wr_data[w0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_queue_full();
        test_pointer_wrap();
        test_turnaround();
        test_push_pop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: RAM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: command queue entries, a power of two of at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 SHALL have port req_ready, output, 1 bit: the queue can accept a request; equals !full.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH bits: target word address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a one-cycle pulse marking read data valid.
REQ-012 SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, held until the next read completes.
REQ-013 SHALL have port idle, output, 1 bit: queue empty and FSM in IDLE.
REQ-014 SHALL have port ram_addr, output, ADDR_WIDTH bits: RAM address.
REQ-015 SHALL have port ram_data, inout, DATA_WIDTH bits: shared RAM data bus.
REQ-016 SHALL have ports ram_cs, ram_we and ram_oe, outputs, 1 bit each: RAM chip select, write enable and output enable.

Function
REQ-017 SHALL accept a request into the queue on any clk edge where req_valid and req_ready are both 1; the queue is FIFO-ordered and holds we, addr and wdata.
REQ-018 SHALL keep an occupancy count from 0 to FIFO_DEPTH; full = (count == FIFO_DEPTH), empty = (count == 0); read and write pointers wrap modulo FIFO_DEPTH.
REQ-019 SHALL handle a push and a pop on the same edge by advancing both pointers and leaving the count unchanged.
REQ-020 SHALL implement FSM states IDLE, WRITE, RD_ADDR, RD_DATA and TURN.
REQ-021 SHALL, in IDLE with the queue not empty, pop the head into a command register and go to WRITE if we = 1, otherwise to RD_ADDR; in IDLE with the queue empty it SHALL stay in IDLE.
REQ-022 SHALL move WRITE -> IDLE, RD_ADDR -> RD_DATA, RD_DATA -> TURN and TURN -> IDLE, each unconditionally after one cycle.
REQ-023 SHALL decode the RAM controls from the state register only, with no combinational path from req_*:
- IDLE and TURN: cs = 0, we = 0, oe = 0.
- WRITE: cs = 1, we = 1, oe = 0.
- RD_ADDR: cs = 1, we = 0, oe = 0.
- RD_DATA: cs = 1, we = 0, oe = 1.
REQ-024 SHALL drive ram_addr from the command register in every non-IDLE state, and hold its last value in IDLE.
REQ-025 SHALL drive ram_data with the command wdata only in WRITE and leave it high-impedance in all other states.
REQ-026 SHALL capture ram_data into rsp_rdata on the edge that leaves RD_DATA, and assert rsp_valid for exactly the following cycle, which is the TURN cycle.
REQ-027 SHALL give read latency as follows: for a read accepted at edge E0 into an empty queue with the FSM in IDLE, the pop happens at E1, the RAM latches at E2, data is captured at E3, and rsp_valid is 1 in the cycle after E3.
REQ-028 SHALL give write latency as follows: for a write accepted at E0 under the same conditions, the pop happens at E1 and the RAM write occurs at E2.
REQ-029 SHALL sustain at most one write per 2 cycles and one read per 4 cycles.
REQ-030 SHALL insert the TURN cycle after every read so that the RAM releases the bus before any controller drive.
REQ-031 SHALL NOT apply backpressure on responses: rsp_valid is never stalled.
REQ-032 SHALL assert idle when the queue is empty and the FSM is in IDLE.

Reset
REQ-033 SHALL, while rst_n = 0, asynchronously force state IDLE, count 0, both pointers 0, ram_cs/ram_we/ram_oe = 0, ram_data high-Z, rsp_valid = 0, rsp_rdata = 0, ram_addr = 0, req_ready = 1 and idle = 1.
REQ-034 SHALL, on reset asserted mid-operation, drop the controls immediately, abort any in-flight command without a response, and discard all queued commands.
REQ-035 SHALL accept a request on the first clk edge after rst_n deasserts.

Verification
REQ-036 SHALL cover single write then read: write addr 3 data 0xDEADBEEF, then read addr 3 -> rsp_valid pulses once with rsp_rdata = 0xDEADBEEF, 3 cycles after the read is accepted into an empty queue.
REQ-037 SHALL cover queue full: 5 back-to-back requests with the FSM held busy -> req_ready = 0 after the 4th accept; no command is lost or duplicated; responses come back in order.
REQ-038 SHALL cover bus turnaround: read addr 1 immediately followed by write addr 2 data 0x12345678 -> ram_data is never driven by both sides; TURN precedes WRITE; a later read of addr 2 returns 0x12345678.
REQ-039 SHALL cover pointer wrap: 10 alternating writes and reads at addrs 0..9 -> every read returns its matching data; count never exceeds 4.
REQ-040 SHALL cover mid-read reset: rst_n low in RD_DATA -> ram_cs = 0 in the same cycle, no rsp_valid, idle = 1 and req_ready = 1 after release.
REQ-041 SHALL cover simultaneous push and pop with count = 2: count stays 2 and FIFO order is preserved.
